// File: rtl/dmem_arbiter.sv
// Shares one data memory between the core (C) and loader (L) ports, one access at a time.
// Define DMEM_ARB_CORE_PRIO_EN for fixed core priority; default build is round-robin.
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_done,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_stall,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_done,
    output logic [DATA_W-1:0] l_rdata,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              busy,
    output logic              owner
);

    // state  | meaning
    // IDLE   | no transaction; arbitrate pending requests
    // ACCESS | memory access; counter runs down to 0, write/capture on 0
    // RESP   | pulse owner's done, record owner as last
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              last, last_nx;
    logic              own, own_nx;
    logic              lat_we, lat_we_nx;
    logic [ADDR_W-1:0] lat_a, lat_a_nx;
    logic [DATA_W-1:0] lat_wd, lat_wd_nx;
    logic [DATA_W-1:0] rdata, rdata_nx;
    logic              grant_l;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            last   <= 1'b1;
            own    <= 1'b0;
            lat_we <= 1'b0;
            lat_a  <= '0;
            lat_wd <= '0;
            rdata  <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            last   <= last_nx;
            own    <= own_nx;
            lat_we <= lat_we_nx;
            lat_a  <= lat_a_nx;
            lat_wd <= lat_wd_nx;
            rdata  <= rdata_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        last_nx   = last;
        own_nx    = own;
        lat_we_nx = lat_we;
        lat_a_nx  = lat_a;
        lat_wd_nx = lat_wd;
        rdata_nx  = rdata;
        grant_l   = 1'b0;
        case (state)
            IDLE: begin
                if (c_req || l_req) begin
`ifdef DMEM_ARB_CORE_PRIO_EN
                    grant_l = l_req & ~c_req;
`else
                    // on a tie, the port that did not go last wins
                    grant_l = l_req & (~c_req | ~last);
`endif
                    own_nx    = grant_l;
                    lat_we_nx = grant_l ? l_we    : c_we;
                    lat_a_nx  = grant_l ? l_addr  : c_addr;
                    lat_wd_nx = grant_l ? l_wdata : c_wdata;
                    cnt_nx    = CNT_INIT;
                    state_nx  = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt != 4'd0) begin
                    cnt_nx = cnt - 4'd1;
                end else begin
                    rdata_nx = mem_rd;
                    state_nx = RESP;
                end
            end
            RESP: begin
                last_nx  = own;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign owner   = own;
    assign mem_a   = busy ? lat_a  : '0;
    assign mem_wd  = busy ? lat_wd : '0;
    // gated by rst so a reset landing on the write cycle never commits it
    assign mem_we  = rst & (state == ACCESS) & (cnt == 4'd0) & lat_we;
    assign c_done  = (state == RESP) & ~own;
    assign l_done  = (state == RESP) & own;
    assign c_rdata = rdata;
    assign l_rdata = rdata;
    assign c_stall = c_req & ~c_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural datamem.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        c_req, c_we, l_req, l_we;
    logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
    logic        c_done, c_stall, l_done, mem_we, busy, owner;
    logic [31:0] c_rdata, l_rdata, mem_a, mem_wd, mem_rd;

    logic [31:0] mem [0:255];
    logic        pre_we;
    logic [7:0]  pre_a;
    logic [31:0] pre_d;

    int n_chk  = 0;
    int n_pass = 0;
    int n_c, n_l;

`ifdef DMEM_ARB_CORE_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_done(c_done), .c_rdata(c_rdata), .c_stall(c_stall),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_done(l_done), .l_rdata(l_rdata),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
        .busy(busy), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we)      mem[pre_a] <= pre_d;
        else if (mem_we) mem[mem_a[7:0]] <= mem_wd;
    end
    assign mem_rd = mem[mem_a[7:0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pre_a  = a;
        pre_d  = d;
        pre_we = 1'b1;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; pre_we = 1'b0; pre_a = '0; pre_d = '0;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;
        tick();
        preload(8'h10, 32'hDEADBEEF);
        preload(8'h30, 32'hAAAA5555);
        do_reset();

        #3;
        chk("rst_busy", busy, 0);
        chk("rst_c_done", c_done, 0);
        chk("rst_l_done", l_done, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_rdata", c_rdata, 0);
        chk("rst_stall", c_stall, 0);
        tick();

        // 1: core read, done at cycle 3
        c_req = 1; c_we = 0; c_addr = 32'h10;
        for (int k = 0; k < 4; k++) begin
            #3;
            chk("t1_done", c_done, 32'(k == 3));
            chk("t1_stall", c_stall, 32'(k < 3));
            chk("t1_we", mem_we, 0);
            chk("t1_l_done", l_done, 0);
            if (k == 3) chk("t1_rdata", c_rdata, 32'hDEADBEEF);
            tick();
        end
        c_req = 0;
        #3; chk("t1_idle", busy, 0);
        tick();

        // 2: loader write, then core readback
        l_req = 1; l_we = 1; l_addr = 32'h20; l_wdata = 32'h12345678;
        for (int k = 0; k < 4; k++) begin
            #3;
            chk("t2_we", mem_we, 32'(k == 2));
            if (k == 2) begin
                chk("t2_mem_a", mem_a, 32'h20);
                chk("t2_mem_wd", mem_wd, 32'h12345678);
            end
            if (k == 1) chk("t2_owner", owner, 1);
            chk("t2_l_done", l_done, 32'(k == 3));
            chk("t2_c_done", c_done, 0);
            tick();
        end
        l_req = 0; l_we = 0;
        #3; chk("t2_mem", mem[8'h20], 32'h12345678);
        tick();
        c_req = 1; c_addr = 32'h20;
        for (int k = 0; k < 4; k++) begin
            #3;
            chk("t2_rd_done", c_done, 32'(k == 3));
            if (k == 3) chk("t2_rd_data", c_rdata, 32'h12345678);
            tick();
        end
        c_req = 0;
        #3; tick();

        // 3/6: both requests held for 20 cycles after reset
        do_reset();
        c_req = 1; c_we = 0; c_addr = 32'h10;
        l_req = 1; l_we = 0; l_addr = 32'h20;
        n_c = 0; n_l = 0;
        for (int k = 0; k < 20; k++) begin
            #3;
            if (PRIO) begin
                chk("t3_c_done", c_done, 32'((k % 4) == 3));
                chk("t3_l_done", l_done, 0);
            end else begin
                chk("t3_c_done", c_done, 32'(k == 3 || k == 11 || k == 19));
                chk("t3_l_done", l_done, 32'(k == 7 || k == 15));
            end
            if (k == 1) chk("t3_owner1", owner, 0);
            if (k == 5) chk("t3_owner5", owner, PRIO ? 0 : 1);
            if (k == 9) chk("t3_owner9", owner, 0);
            n_c += int'(c_done);
            n_l += int'(l_done);
            tick();
        end
        chk("t6_n_c", n_c, PRIO ? 5 : 3);
        chk("t6_n_l", n_l, PRIO ? 0 : 2);
        c_req = 0; l_req = 0;
        #3; chk("t3_idle", busy, 0);
        tick();

        // 4: reset while loader write has counter=1
        l_req = 1; l_we = 1; l_addr = 32'h30; l_wdata = 32'h11112222;
        #3; tick();
        rst = 0; l_req = 0;
        #3;
        chk("t4_we_rst", mem_we, 0);
        chk("t4_busy_rst", busy, 1);
        tick();
        rst = 1;
        for (int k = 0; k < 3; k++) begin
            #3;
            chk("t4_busy", busy, 0);
            chk("t4_l_done", l_done, 0);
            chk("t4_we", mem_we, 0);
            tick();
        end
        chk("t4_mem", mem[8'h30], 32'hAAAA5555);
        chk("t4_rdata", l_rdata, 0);

        // 4b: reset landing on the write cycle itself
        l_req = 1; l_we = 1; l_addr = 32'h30; l_wdata = 32'h33334444;
        #3; tick();
        #3; tick();
        rst = 0; l_req = 0;
        #3;
        chk("t4b_we_rst", mem_we, 0);
        chk("t4b_mem_a", mem_a, 32'h30);
        tick();
        rst = 1;
        #3;
        chk("t4b_busy", busy, 0);
        chk("t4b_l_done", l_done, 0);
        chk("t4b_mem", mem[8'h30], 32'hAAAA5555);
        tick();
        l_we = 0;

        // 5: core request dropped after grant, inputs changed
        c_req = 1; c_we = 0; c_addr = 32'h10;
        #3; tick();
        c_req = 0; c_we = 1; c_addr = 32'h99;
        #3; chk("t5_busy", busy, 1);
        tick();
        #3;
        chk("t5_mem_a", mem_a, 32'h10);
        chk("t5_we", mem_we, 0);
        tick();
        #3;
        chk("t5_done", c_done, 1);
        chk("t5_rdata", c_rdata, 32'hDEADBEEF);
        chk("t5_stall", c_stall, 0);
        tick();
        for (int k = 0; k < 2; k++) begin
            #3;
            chk("t5_idle", busy, 0);
            chk("t5_no_done", c_done, 0);
            tick();
        end
        c_we = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single data memory (datamem: synchronous write, combinational read) between two requesters. Port C is the core load/store path; port L is the program loader/debug path. Runs a per-access FSM with a programmable memory wait count. Issues one grant at a time using round-robin arbitration, and produces a stall for the core so the PC holds until its access completes.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, cycles spent in ACCESS per transaction (legal range 1..15)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset; synchronous, active-low
c_req  in  1  core request, held until c_done
c_we  in  1  core write (1) / read (0)
c_addr  in  ADDR_W  core address
c_wdata  in  DATA_W  core write data
c_done  out  1  one-cycle completion pulse to core
c_rdata  out  DATA_W  read data, valid in the c_done cycle
c_stall  out  1  c_req & ~c_done, combinational
l_req, l_we, l_addr, l_wdata  in  1/1/ADDR_W/DATA_W  loader equivalents of the c_ inputs
l_done  out  1  loader completion pulse
l_rdata  out  DATA_W  loader read data, valid in the l_done cycle
mem_a  out  ADDR_W  memory address
mem_wd  out  DATA_W  memory write data
mem_we  out  1  memory write enable
mem_rd  in  DATA_W  memory read data (combinational from mem_a)
busy  out  1  state != IDLE
owner  out  1  0 = core, 1 = loader; valid while busy

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE, last=1 (core wins the first tie), counter=0.
  - Latched addr/wdata/we=0, rdata register=0.
  - c_done=l_done=0.
- mem_we is combinationally forced 0 whenever rst=0, so a reset asserted mid-write never commits the write.
- States are IDLE, ACCESS and RESP.
- IDLE:
  - No request: stay.
  - Any request: select the winner, latch its addr/wdata/we, set owner, counter=MEM_LAT-1, go to ACCESS.
  - Round-robin: with both requesting, grant the port != last; with one requesting, grant it.
- ACCESS:
  - mem_a/mem_wd are driven from the latched values.
  - mem_we = latched we only while counter==0, so exactly one write pulse per write.
  - counter!=0: decrement.
  - counter==0: capture mem_rd into the rdata register, go to RESP.
- RESP:
  - Pulse the owner's done for one cycle and set last=owner.
  - Go to IDLE; no grant is made in the RESP cycle.
- c_rdata and l_rdata both drive the rdata register; each is meaningful only with its own done. On writes the register still captures mem_rd.
- mem_a and mem_wd are 0 in IDLE; mem_we=0 outside the final ACCESS cycle.
- Latency: request seen in IDLE at cycle 0 gives done at cycle MEM_LAT+1, and IDLE again at MEM_LAT+2. Throughput is one access per MEM_LAT+2 cycles.
- Request dropped after grant: the transaction is committed; it completes and done still pulses.
- Request inputs changing after grant: ignored (values are latched).
- Request still high in the IDLE cycle after done: treated as a new transaction.
- Owner never changes while busy.
- Reset during any state: IDLE at the next edge, no done pulse, all outputs at reset values.
- Addresses and data pass through unmodified; no alignment checks.

Optional Feature:
DMEM_ARB_CORE_PRIO_EN
- Defined: fixed priority. Core always wins a tie; `last` is still updated but ignored for selection. The loader can starve while the core requests continuously.
- Undefined: round-robin as described above.

Test Plan:
1. MEM_LAT=2, mem[0x10]=0xDEADBEEF; c_req=1, c_we=0, c_addr=0x10 at cycle 0 -> c_done=1 only at cycle 3, c_rdata=0xDEADBEEF, mem_we never 1, c_stall=1 in cycles 0-2 and 0 in cycle 3.
2. l_req write 0x20<-0x12345678 -> mem_we=1 only at cycle 2 with mem_a=0x20 and mem_wd=0x12345678; l_done at cycle 3; a following core read of 0x20 returns 0x12345678.
3. After reset, c_req and l_req both assert at cycle 0 and are held -> core done at cycle 3, loader granted at cycle 4 and done at cycle 7; with both still held, the next grant goes to the core (alternation).
4. Loader write in ACCESS with counter=1, rst=0 for one cycle -> mem_we stays 0, state IDLE next cycle, l_done never pulses, memory unchanged.
5. c_req dropped at cycle 1 after its grant -> c_done still pulses at cycle 3; no second transaction starts.
6. DMEM_ARB_CORE_PRIO_EN defined, both requests held continuously -> only c_done ever pulses over 20 cycles; undefined -> c_done and l_done alternate.
